lsu_byte_sum_stream: RTL
========================

Name: lsu_byte_sum_stream

Overview:
- Parametrised successor to the single-word load/accelerate/store unit.
- Streams `count_i` words from memory and sums the bytes of each word.
- Writes results back either per word (mode 0) or as one accumulated total (mode 1).
- A load-data FIFO decouples the load and store sides, so loads run ahead while stores are back-pressured. Sits between the control core and the iob-cache memory port.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, >=16. LANES = DATA_WIDTH/8.
- ADDR_WIDTH, 22, byte-address width.
- CNT_WIDTH, 22, width of word count.
- FIFO_DEPTH, 4, load-data FIFO entries; power of two, >=2.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- mode_i  in  1  0 = per-word store, 1 = single accumulated store; latched at start.
- load_base_addr_i  in  ADDR_WIDTH  first load byte address; latched at start.
- store_base_addr_i  in  ADDR_WIDTH  first/only store byte address; latched at start.
- count_i  in  CNT_WIDTH  number of words to process; latched at start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle completion pulse.
- load_req_o  out  1  load request; held until load_complete_i.
- load_addr_o  out  ADDR_WIDTH  load byte address.
- load_data_i  in  DATA_WIDTH  load data; valid with load_complete_i.
- load_complete_i  in  1  one-cycle load acknowledge.
- store_req_o  out  1  store request; held until store_complete_i.
- store_addr_o  out  ADDR_WIDTH  store byte address.
- store_data_o  out  DATA_WIDTH  store data; stable while store_req_o is high.
- store_complete_i  in  1  one-cycle store acknowledge.

Behaviour:
- Reset:
  - All outputs are 0. FSM goes to IDLE. FIFO is emptied.
  - Counters and accumulator are cleared. Any in-flight transaction is abandoned, with no completion expected.
- FSM:
  - IDLE: start_i -> RUN; latch inputs.
  - RUN: runs while loads_issued<count or the FIFO is non-empty or a store is pending.
  - RUN -> FINAL when mode=1 and all words are summed.
  - RUN -> DONE when mode=0 and all stores are complete.
  - FINAL issues one store and moves to DONE on store_complete_i.
  - DONE: done_o=1 for one cycle, then IDLE.
- count=0: RUN->DONE immediately; no load or store requests. done_o is high 2 cycles after start.
- Load side:
  - At most one outstanding load.
  - A load issues when loads_issued<count and (fifo_used + outstanding) < FIFO_DEPTH.
  - The first load_req_o is asserted the cycle after start.
  - load_addr = load_base + i*LANES, modulo 2^ADDR_WIDTH (wraps).
  - On load_complete_i, data is pushed into the FIFO and load_req_o is dropped in the same edge. The next request is no earlier than the following cycle.
  - load_complete_i with no outstanding load is ignored.
- Sum:
  - byte_sum = unsigned sum of LANES bytes. Width is 8+clog2(LANES), zero-extended to DATA_WIDTH.
  - Mode 1 accumulator is DATA_WIDTH bits and wraps modulo 2^DATA_WIDTH.
- Store side, mode 0:
  - When the FIFO is non-empty and no store is pending, pop, register the sum into store_data_o, and raise store_req_o on the next edge.
  - store_addr = store_base + j*LANES (wraps).
  - The next pop is allowed on the cycle after store_complete_i.
- Store side, mode 1:
  - Pop every cycle the FIFO is non-empty and accumulate; no stores in RUN.
  - In FINAL, store_data_o = accumulator and store_addr_o = store_base.
- Simultaneous events:
  - FIFO push and pop in the same cycle are both legal; occupancy is unchanged.
  - Push while full cannot occur because of the issue rule.
- start_i while busy is ignored, with no effect on latched values.
- arst_i mid-operation: outputs go to 0 immediately (asynchronous); the block restarts cleanly on the next start_i.

Test Plan:
- mem[0]=0x01020304, load_base=0, store_base=4, count=1, mode=0, immediate acks -> mem[1]=0x0000000A; 1 load, 1 store, 1 done pulse.
- mem[0..3]=0x01020304, 0xFFFFFFFF, 0x00000000, 0x10101010, count=4, mode=0 -> mem[4..7]=0x0A, 0x3FC, 0x00, 0x40 when store_base=0x10; addresses step by 4.
- Same data, mode=1, store_base=0x20 -> single store 0x00000446 at 0x20; exactly 4 loads, 1 store.
- Back-pressure: count=8, mode=0, store_complete_i delayed 20 cycles -> FIFO occupancy never exceeds 4; loads_issued - stores_completed <= 5 (4 FIFO entries plus the 1 popped word held in the pending store); all 8 results correct.
- Edge cases:
  - count=0 -> no requests; done_o 2 cycles after start.
  - load_base=0x3FFFFC, count=2 -> second load_addr=0x000000 (wrap).
- arst_i asserted while store_req_o is high -> all outputs 0 the same cycle. A subsequent count=1 run passes as in the first scenario.

Source files
------------

// File: rtl/lsu_byte_sum_stream.sv
// -----------------------------------------------------------------------------
// lsu_byte_sum_stream
//
// Streams a block of words from memory, reduces every word to the unsigned sum
// of its bytes and writes the results back. In mode 0 each word produces its
// own store at consecutive store addresses; in mode 1 all byte sums are folded
// into one accumulator that is written once, at the store base address, after
// the last word has been summed.
//
// A small load-data FIFO sits between the load and store sides so loads keep
// running ahead while the store side is back-pressured by a slow memory port.
//
// Ports:
//   clk_i              clock, rising edge
//   arst_i             asynchronous active-high reset
//   start_i            one-cycle start pulse, honoured only while idle
//   mode_i             0 = one store per word, 1 = one accumulated store
//   load_base_addr_i   byte address of the first word to load
//   store_base_addr_i  byte address of the first (or only) store
//   count_i            number of words to process (0 is a legal empty job)
//   busy_o             job in progress (cycle after accepted start .. done)
//   done_o             one-cycle completion pulse
//   load_req_o         load request, held until load_complete_i
//   load_addr_o        load byte address
//   load_data_i        load return data, valid with load_complete_i
//   load_complete_i    one-cycle load acknowledge
//   store_req_o        store request, held until store_complete_i
//   store_addr_o       store byte address
//   store_data_o       store data, stable while store_req_o is high
//   store_complete_i   one-cycle store acknowledge
// -----------------------------------------------------------------------------
module lsu_byte_sum_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 22,
   parameter int CNT_WIDTH  = 22,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  start_i,
   input  logic                  mode_i,
   input  logic [ADDR_WIDTH-1:0] load_base_addr_i,
   input  logic [ADDR_WIDTH-1:0] store_base_addr_i,
   input  logic [CNT_WIDTH-1:0]  count_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  load_req_o,
   output logic [ADDR_WIDTH-1:0] load_addr_o,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   input  logic                  load_complete_i,
   output logic                  store_req_o,
   output logic [ADDR_WIDTH-1:0] store_addr_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   input  logic                  store_complete_i
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int LANES     = DATA_WIDTH / 8;
   localparam int SUM_WIDTH = 8 + $clog2(LANES);
   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(LANES);
   localparam logic [PTR_WIDTH:0]    FIFO_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [PTR_WIDTH:0]    USED_ONE  = (PTR_WIDTH + 1)'(1);
   localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = PTR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // ---------------------------------------------------------------------------
   // Byte reduction: unsigned sum of all byte lanes, zero-extended to a word.
   // The SUM_WIDTH intermediate is exactly wide enough for LANES * 255.
   // ---------------------------------------------------------------------------
   function automatic logic [DATA_WIDTH-1:0] byte_sum(input logic [DATA_WIDTH-1:0] word);
      logic [SUM_WIDTH-1:0] sum;
      // NOTE: blocking assignments are correct here -- 'sum' is a function-local
      // temporary built up step by step, not a clocked register.
      sum = '0;
      for (int i = 0; i < LANES; i++) begin
         sum = sum + SUM_WIDTH'(word[8*i +: 8]);
      end
      return DATA_WIDTH'(sum);
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]            state;
   logic                  mode_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic [CNT_WIDTH-1:0]  loads_issued;
   logic [CNT_WIDTH-1:0]  words_popped;
   logic [ADDR_WIDTH-1:0] load_addr_next;
   // In mode 1 this never advances, so it still holds the store base when the
   // single accumulated store is issued.
   logic [ADDR_WIDTH-1:0] store_addr_next;
   logic [DATA_WIDTH-1:0] acc;

   // Load-data FIFO
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH:0]    fifo_used;

   // ---------------------------------------------------------------------------
   // Handshake and datapath decisions
   // ---------------------------------------------------------------------------
   logic                  fifo_empty;
   logic                  load_accept;
   logic                  store_accept;
   logic                  load_issue;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  all_popped;
   logic [DATA_WIDTH-1:0] head_sum;

   assign fifo_empty   = (fifo_used == '0);

   // Acknowledges arriving with no request outstanding are ignored.
   assign load_accept  = load_req_o  & load_complete_i;
   assign store_accept = store_req_o & store_complete_i;

   // At most one load outstanding; a new one only when the word it returns is
   // guaranteed a FIFO slot. While a load is outstanding load_req_o is high,
   // so "fifo_used + outstanding < depth" reduces to "fifo_used < depth" here.
   assign load_issue   = (state == ST_RUN) && !load_req_o &&
                         (loads_issued < count_q) && (fifo_used < FIFO_FULL);

   assign fifo_push    = load_accept;

   // Mode 1 drains the FIFO every cycle; mode 0 pops only when the previous
   // store has been acknowledged (store_req_o low again).
   assign fifo_pop     = (state == ST_RUN) && !fifo_empty && (mode_q || !store_req_o);

   assign all_popped   = (words_popped == count_q);
   assign head_sum     = byte_sum(fifo_mem[rd_ptr]);

   assign busy_o       = (state != ST_IDLE);
   assign done_o       = (state == ST_DONE);

   // ---------------------------------------------------------------------------
   // FIFO storage
   // ---------------------------------------------------------------------------
   // NOTE: the data array has no reset; emptiness is defined purely by the
   // pointers and occupancy count below, so stale entries are never read.
   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr] <= load_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_used <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_used <= fifo_used + USED_ONE;
            2'b01:   fifo_used <= fifo_used - USED_ONE;
            default: fifo_used <= fifo_used;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM, load side and store side
   // ---------------------------------------------------------------------------
   // NOTE: every register in a clocked block is updated with non-blocking
   // assignments so all decisions in a cycle see the pre-edge values.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state           <= ST_IDLE;
         mode_q          <= 1'b0;
         count_q         <= '0;
         loads_issued    <= '0;
         words_popped    <= '0;
         load_addr_next  <= '0;
         store_addr_next <= '0;
         acc             <= '0;
         load_req_o      <= 1'b0;
         load_addr_o     <= '0;
         store_req_o     <= 1'b0;
         store_addr_o    <= '0;
         store_data_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state           <= ST_RUN;
                  mode_q          <= mode_i;
                  count_q         <= count_i;
                  words_popped    <= '0;
                  acc             <= '0;
                  store_addr_next <= store_base_addr_i;
                  // The first load goes out on the same edge that accepts the
                  // start, so load_req_o is visible the cycle after start_i.
                  if (count_i != '0) begin
                     load_req_o     <= 1'b1;
                     load_addr_o    <= load_base_addr_i;
                     load_addr_next <= load_base_addr_i + ADDR_STEP;
                     loads_issued   <= CNT_ONE;
                  end else begin
                     load_addr_next <= load_base_addr_i;
                     loads_issued   <= '0;
                  end
               end
            end

            ST_RUN: begin
               // Load side: drop on acknowledge; the next request can only be
               // raised on a later edge.
               if (load_accept) begin
                  load_req_o <= 1'b0;
               end else if (load_issue) begin
                  load_req_o     <= 1'b1;
                  load_addr_o    <= load_addr_next;
                  load_addr_next <= load_addr_next + ADDR_STEP;
                  loads_issued   <= loads_issued + CNT_ONE;
               end

               // Store side (mode 0 stores only happen here).
               if (store_accept) begin
                  store_req_o <= 1'b0;
               end

               if (fifo_pop) begin
                  words_popped <= words_popped + CNT_ONE;
                  if (mode_q) begin
                     acc <= acc + head_sum;
                  end else begin
                     store_req_o     <= 1'b1;
                     store_data_o    <= head_sum;
                     store_addr_o    <= store_addr_next;
                     store_addr_next <= store_addr_next + ADDR_STEP;
                  end
               end

               // Completion. all_popped implies every load has returned and the
               // FIFO is empty; in mode 1 the last addition already landed in acc.
               if (count_q == '0) begin
                  state <= ST_DONE;
               end else if (mode_q && all_popped) begin
                  state        <= ST_FINAL;
                  store_req_o  <= 1'b1;
                  store_data_o <= acc;
                  store_addr_o <= store_addr_next;
               end else if (!mode_q && all_popped && !store_req_o) begin
                  state <= ST_DONE;
               end
            end

            ST_FINAL: begin
               if (store_accept) begin
                  store_req_o <= 1'b0;
                  state       <= ST_DONE;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
